// File: rtl/neander_muldiv_ctrl.sv
// Sequences NEANDER-X MUL/DIV/MOD: accepts a request, launches the selected iterative engine, waits for done under a watchdog.
// Latency: accept at T, start pulse at T+1, response one cycle after the engine done strobe (or after the watchdog expires).
// Backpressure: one operation in flight; req_ready is low from accept until the response handshake completes; rsp_* held while stalled.
module neander_muldiv_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        abort,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_lo,
    input  logic [15:0] mul_hi,
    output logic        div_start,
    input  logic        div_done,
    input  logic [15:0] div_quot,
    input  logic [15:0] div_rem,
    input  logic        div_by_zero,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [15:0] rsp_high,
    output logic        rsp_carry,
    output logic        rsp_timeout
);

    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_MOD = 4'b1011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] result;
        logic [15:0] high;
        logic        carry;
        logic        timeout;
    } rsp_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rsp_t             rsp_q, rsp_d;

    logic is_mul;
    logic is_div;
    logic sel_done;
    rsp_t cap;

    function automatic logic is_seq_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

    assign is_mul   = (op_q == OP_MUL);
    assign is_div   = (op_q == OP_DIV) || (op_q == OP_MOD);
    // Only the engine that was launched may complete the operation.
    assign sel_done = is_mul ? mul_done : div_done;

    always_comb begin
        cap = '0;
        if (is_mul) begin
            cap.result = mul_lo;
            cap.high   = mul_hi;
            cap.carry  = (mul_hi != 16'h0000);
        end else if (op_q == OP_DIV) begin
            cap.result = div_quot;
            cap.high   = div_rem;
            cap.carry  = div_by_zero;
        end else begin
            cap.result = div_rem;
            cap.high   = div_quot;
            cap.carry  = div_by_zero;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    if (is_seq_op(req_op)) begin
                        state_d = S_LAUNCH;
                    end else begin
                        rsp_d   = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Priority: abort, then done, then watchdog expiry.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sel_done) begin
                    rsp_d   = cap;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_d.result  = 16'h0000;
                    rsp_d.high    = 16'h0000;
                    rsp_d.carry   = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign mul_start   = (state_q == S_LAUNCH) && is_mul;
    assign div_start   = (state_q == S_LAUNCH) && is_div;
    assign op_a        = a_q;
    assign op_b        = b_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = rsp_q.result;
    assign rsp_high    = rsp_q.high;
    assign rsp_carry   = rsp_q.carry;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/neander_muldiv_ctrl.md
Name: neander_muldiv_ctrl

Overview:
Sequencing controller for the NEANDER-X multi-cycle ALU operations: MUL (4'b1001), DIV (4'b1010) and MOD (4'b1011).
- Accepts one operation request from the control unit over a valid/ready handshake.
- Launches the sequential multiplier or the sequential divider, waits for its done strobe with a watchdog, and formats the result.
- Returns result, high word (to Y) and carry over a valid/ready response handshake.
- Sits between the control unit FSM and the two iterative engines. It replaces ad-hoc fixed-cycle waiting in the control unit.

Parameters:
TIMEOUT_CYCLES, 40, WAIT-state cycles allowed before the engine is declared hung; must be >= 2.
CNT_W, 6, watchdog counter width; 2**CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  operation request valid
req_ready  out  1  controller can accept a request
req_op  in  4  ALU opcode
req_a  in  16  operand a (AC)
req_b  in  16  operand b (memory operand)
abort  in  1  cancel in-flight operation
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  multiplier finished
mul_lo  in  16  product low word
mul_hi  in  16  product high word
div_start  out  1  one-cycle start pulse to divider
div_done  in  1  divider finished
div_quot  in  16  quotient
div_rem  in  16  remainder
div_by_zero  in  1  divisor was zero
op_a  out  16  latched operand a to both engines
op_b  out  16  latched operand b to both engines
rsp_valid  out  1  response valid
rsp_ready  in  1  control unit accepts response
rsp_result  out  16  value for AC
rsp_high  out  16  value for Y
rsp_carry  out  1  carry flag
rsp_timeout  out  1  watchdog expired for this response

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; counter 0; latched operands 0.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b.
  - MUL/DIV/MOD -> LAUNCH.
  - Any other opcode -> RESP with result=0, high=0, carry=0, timeout=0.
- LAUNCH (exactly 1 cycle):
  - Assert mul_start for MUL, div_start for DIV/MOD; never both.
  - Clear counter. -> WAIT.
  - A done strobe arriving in this cycle is ignored.
- WAIT:
  - Sample only the selected engine's done; the other engine's done is ignored.
  - On done, capture and go to RESP:
    - MUL: result=mul_lo, high=mul_hi, carry=(mul_hi!=0).
    - DIV: result=div_quot, high=div_rem, carry=div_by_zero.
    - MOD: result=div_rem, high=div_quot, carry=div_by_zero.
  - Without done, the counter increments each cycle.
  - When counter==TIMEOUT_CYCLES-1 and done is low -> RESP with result=0, high=0, carry=1, timeout=1.
  - Done in that same cycle wins (normal capture, timeout=0).
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then -> IDLE.
  - req_ready returns next cycle; no same-cycle bypass.
- abort:
  - In LAUNCH or WAIT -> IDLE next cycle, no response, no further start pulses.
  - Ignored in IDLE and RESP.
  - Abort has priority over done and timeout.
- op_a/op_b are stable from LAUNCH until the next accept.
- start outputs are combinational from state LAUNCH and registered-state only; no combinational path from req_* to start.
- Latency:
  - Accept at cycle T; start at T+1.
  - Engine done at cycle D (D>=T+2) gives rsp_valid at D+1.
- Engine done pulses while IDLE or RESP have no effect.
- rsp_* outputs other than rsp_valid keep their last value in IDLE.
- Reset asserted mid-operation returns to IDLE immediately. Next operation starts from a fresh launch.

Test Plan:
- MUL a=16'h0300, b=16'h0200; multiplier done 16 cycles after start with lo=16'h0000, hi=16'h0006 -> rsp_result=0000, rsp_high=0006, rsp_carry=1; mul_start one cycle at T+1; div_start never asserted.
- DIV 100/7, then MOD 100/7 back-to-back with rsp_ready held 1 -> first response result=14, high=2, carry=0; second result=2, high=14; req_ready low throughout each operation.
- DIV b=0, divider done with div_by_zero=1, quot=FFFF, rem=0064 -> result=FFFF, high=0064, carry=1, timeout=0.
- Watchdog: MUL started, done never asserted, TIMEOUT_CYCLES=40 -> rsp_valid 41 cycles after start with timeout=1, carry=1, result=0. Repeat with done on the 40th WAIT cycle -> normal capture, timeout=0.
- abort on 5th WAIT cycle, then stray mul_done 3 cycles later -> no rsp_valid; req_ready=1 one cycle after abort; stray done ignored. Illegal opcode 4'b0000 -> immediate response of zeros.
- Backpressure: rsp_ready low 10 cycles -> rsp_* stable and req_ready low; rst_n pulsed during WAIT -> all outputs at reset values asynchronously.
